// File: rtl/ff_deser_pkg.sv
// Shared types and constants for the bit-FIFO deserializer.
// Optional feature macro: FF_DESER_PARITY_EN (adds a trailing even-parity bit per frame).
package ff_pkg;

  localparam int FF_WORD_W = 8;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } ff_state_e;

  // Number of serial bits making up one frame for a given word width.
  function automatic int frame_len(input int width);
`ifdef FF_DESER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/ff_deser_if.sv
// Bus between the deserializer, its upstream bit FIFO and the word consumer.
// master = deserializer side, slave = environment side.
// Optional feature macro: FF_DESER_PARITY_EN (adds parity_err).
interface ff_deser_if
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_WORD_W
);

  logic             data_o;
  logic             read_valid;
  logic             read_enable;
  logic [WIDTH-1:0] word_o;
  logic             word_valid;
  logic             word_ready;
`ifdef FF_DESER_PARITY_EN
  logic             parity_err;
`endif

  modport master (
    input  data_o,
    input  read_valid,
    input  word_ready,
    output read_enable,
    output word_o,
`ifdef FF_DESER_PARITY_EN
    output parity_err,
`endif
    output word_valid
  );

  modport slave (
    output data_o,
    output read_valid,
    output word_ready,
    input  read_enable,
    input  word_o,
`ifdef FF_DESER_PARITY_EN
    input  parity_err,
`endif
    input  word_valid
  );

endinterface

// File: rtl/ff_deser.sv
// Serial-to-parallel deserializer pulling one bit at a time from an upstream FIFO.
// Bits arrive LSB first; a complete word is held until the consumer accepts it.
// Optional feature macro: FF_DESER_PARITY_EN (frame gets a trailing even-parity bit).
//
// state | meaning
// REQ   | read_enable high, one bit requested from the FIFO
// WAIT  | waiting for the FIFO answer; capture on read_valid, re-request if empty
// HOLD  | full word on word_o, word_valid high until word_ready
module ff_deser
  import ff_pkg::*;
#(
  parameter int WIDTH = FF_WORD_W
) (
  input logic        clk,
  input logic        rst,
  ff_deser_if.master bus
);

  localparam int FRAME = frame_len(WIDTH);
  // Sized to hold the frame length itself, which is the count on entry to HOLD.
  localparam int CNT_W = $clog2(FRAME + 1);

  ff_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
`ifdef FF_DESER_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= REQ;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef FF_DESER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
`ifdef FF_DESER_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state, bit capture and frame completion.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef FF_DESER_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      REQ: state_d = WAIT;
      WAIT: begin
        if (bus.read_valid) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt_q == CNT_W'(i)) shift_d[i] = bus.data_o;
          end
`ifdef FF_DESER_PARITY_EN
          // The parity bit is the last of the frame, so this lands on entry to HOLD.
          if (bit_cnt_q == CNT_W'(WIDTH)) par_err_d = (^shift_q) != bus.data_o;
`endif
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME - 1)) state_d = HOLD;
          else                                state_d = REQ;
        end else begin
          state_d = REQ;
        end
      end
      HOLD: begin
        if (bus.word_ready) begin
          bit_cnt_d = '0;
          state_d   = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // No request goes out while reset is held, even though the state already reads REQ.
  assign bus.read_enable = (state_q == REQ) && !rst;
  assign bus.word_valid  = (state_q == HOLD);
  assign bus.word_o      = shift_q;
`ifdef FF_DESER_PARITY_EN
  assign bus.parity_err  = par_err_q;
`endif

endmodule

// File: tb/tb_ff_deser.sv
// Directed bench for ff_deser: table of frames plus a mid-frame reset sequence.
// Build with FF_DESER_PARITY_EN defined to include the parity frames.
module tb_ff_deser;
  import ff_pkg::*;

  localparam int W = 8;
`ifdef FF_DESER_PARITY_EN
  localparam int FRAME_B = W + 1;
`else
  localparam int FRAME_B = W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ff_deser_if #(.WIDTH(W)) bus ();
  ff_deser #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] win;
    logic       pin;
    int         emp;
    int         hold;
    logic [7:0] exp_w;
    logic       exp_p;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Acts as upstream FIFO and consumer for one frame; stray read_valid is driven while in HOLD.
  task automatic run_frame(input int k, input vec_t v);
    int         idx = 0;
    int         emp = v.emp;
    int         lat = 0;
    int         vcyc = 0;
    int         hcnt = 0;
    int         budget = 0;
    bit         started = 0;
    bit         seen = 0;
    bit         done = 0;
    logic [7:0] held = '0;
    while (!done && budget < 300) begin
      @(negedge clk);
      budget++;
      if (started) lat++;
      else if (bus.read_enable) started = 1;
      if (bus.word_valid) begin
        vcyc++;
        if (!seen) begin
          seen = 1;
          held = bus.word_o;
          chk($sformatf("f%0d latency", k), lat, 2 * (FRAME_B + v.emp));
          chk($sformatf("f%0d word", k), {24'h0, bus.word_o}, {24'h0, v.exp_w});
`ifdef FF_DESER_PARITY_EN
          chk($sformatf("f%0d parity_err", k), {31'h0, bus.parity_err}, {31'h0, v.exp_p});
`endif
        end else begin
          chk($sformatf("f%0d word stable", k), {24'h0, bus.word_o}, {24'h0, held});
        end
        chk($sformatf("f%0d bit_cnt in hold", k), 32'(dut.bit_cnt_q), FRAME_B);
        chk($sformatf("f%0d read_enable in hold", k), {31'h0, bus.read_enable}, 32'h0);
        bus.read_valid = 1'b1;
        bus.data_o     = ~bus.data_o;
        if (hcnt < v.hold) begin
          hcnt++;
          bus.word_ready = 1'b0;
        end else begin
          bus.word_ready = 1'b1;
          done = 1;
        end
      end else if (bus.read_enable) begin
        if (emp > 0) begin
          emp--;
          bus.read_valid = 1'b0;
        end else begin
          bus.read_valid = 1'b1;
          bus.data_o     = (idx < W) ? v.win[idx] : v.pin;
          idx++;
        end
      end
    end
    chk($sformatf("f%0d completed in budget", k), {31'h0, done}, 32'h1);
    if (done) begin
      @(posedge clk);
      #1;
      chk($sformatf("f%0d valid cycles", k), vcyc, v.hold + 1);
      chk($sformatf("f%0d word_valid after accept", k), {31'h0, bus.word_valid}, 32'h0);
      chk($sformatf("f%0d read_enable after accept", k), {31'h0, bus.read_enable}, 32'h1);
    end
    bus.word_ready = 1'b0;
    bus.read_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   idx;
    int   budget;
    bit   spurious;

    vecs.push_back('{8'h4D, 1'b0, 0, 0,  8'h4D, 1'b0});
    vecs.push_back('{8'hFF, 1'b0, 5, 0,  8'hFF, 1'b0});
    vecs.push_back('{8'h5A, 1'b0, 0, 10, 8'h5A, 1'b0});
    vecs.push_back('{8'h80, 1'b1, 0, 2,  8'h80, 1'b0});
    vecs.push_back('{8'h01, 1'b1, 1, 0,  8'h01, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 0, 0,  8'h00, 1'b0});
`ifdef FF_DESER_PARITY_EN
    vecs.push_back('{8'h03, 1'b0, 0, 0,  8'h03, 1'b0});
    vecs.push_back('{8'h03, 1'b1, 0, 3,  8'h03, 1'b1});
`endif

    rst            = 1'b1;
    bus.data_o     = 1'b0;
    bus.read_valid = 1'b0;
    bus.word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset read_enable", {31'h0, bus.read_enable}, 32'h0);
    chk("reset word_valid", {31'h0, bus.word_valid}, 32'h0);
    chk("reset bit_cnt", 32'(dut.bit_cnt_q), 32'h0);
    rst = 1'b0;
    #1;
    chk("read_enable after reset", {31'h0, bus.read_enable}, 32'h1);

    for (int k = 0; k < vecs.size(); k++) run_frame(k, vecs[k]);

    // Mid-frame reset: four 1-bits captured, then reset, then a clean 8'hA5 frame.
    idx      = 0;
    budget   = 0;
    spurious = 0;
    while (idx < 4 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (bus.word_valid) spurious = 1;
      if (bus.read_enable) begin
        bus.read_valid = 1'b1;
        bus.data_o     = 1'b1;
        idx++;
      end
    end
    chk("partial bits issued", idx, 4);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.read_valid = 1'b0;
    chk("partial bit_cnt", 32'(dut.bit_cnt_q), 32'h4);
    chk("no word from partial", {31'h0, spurious | bus.word_valid}, 32'h0);
    rst = 1'b1;
    #1;
    chk("read_enable in reset cycle", {31'h0, bus.read_enable}, 32'h0);
    @(posedge clk);
    #1;
    chk("read_enable held in reset", {31'h0, bus.read_enable}, 32'h0);
    chk("mid reset bit_cnt", 32'(dut.bit_cnt_q), 32'h0);
    chk("mid reset shift", 32'(dut.shift_q), 32'h0);
    chk("mid reset word_valid", {31'h0, bus.word_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("read_enable after mid reset", {31'h0, bus.read_enable}, 32'h1);
    v = '{8'hA5, 1'b0, 0, 0, 8'hA5, 1'b0};
    run_frame(99, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
